// File: rtl/mmio_console_pkg.sv
// -----------------------------------------------------------------------------
// mmio_console_pkg
//   Shared definitions for the MMIO console responder.
//   - reg_off_e      : word offsets inside the 16-byte register window
//   - STAT_*         : bit positions inside the STATUS register
//   - pack_status()  : assembles the STATUS read word
// -----------------------------------------------------------------------------
package mmio_console_pkg;

    // Word offsets, taken from adr[3:2].
    typedef enum logic [1:0] {
        OFF_EXIT   = 2'd0,
        OFF_TX     = 2'd1,
        OFF_STATUS = 2'd2,
        OFF_CYCLE  = 2'd3
    } reg_off_e;

    // STATUS register layout.
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       overflow,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                                      = '0;
        word[STAT_EMPTY]                          = empty;
        word[STAT_FULL]                           = full;
        word[STAT_OVERFLOW]                       = overflow;
        word[STAT_COUNT_LSB +: STAT_COUNT_W]      = count;
        return word;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// -----------------------------------------------------------------------------
// mmio_console_if
//   CPU data-memory request bus as seen by memory-mapped responders.
//   Request (master -> slave): r_v, w_v, adr, data, strobe
//   Response (slave -> master): resp, ack
//   modport master : the CPU / bus driver
//   modport slave  : a responder such as mmio_console
// -----------------------------------------------------------------------------
interface mmio_console_if #(
    parameter int xlen = 32
);
    logic              r_v;
    logic              w_v;
    logic [xlen-1:0]   adr;
    logic [xlen-1:0]   data;
    logic [xlen/8-1:0] strobe;
    logic [xlen-1:0]   resp;
    logic              ack;

    modport master (
        output r_v, w_v, adr, data, strobe,
        input  resp, ack
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe,
        output resp, ack
    );
endinterface

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   Single-clock FIFO, reusable. Pointers carry one extra MSB so that full and
//   empty are distinguished without a separate counter.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write wr_data (ignored when full unless a pop happens too)
//   pop       : drop the head entry (ignored when empty)
//   rd_data   : head entry, forced to 0 while empty
//   full/empty/count : occupancy
// -----------------------------------------------------------------------------
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, so a streaming producer never loses a byte.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers discards its
    // contents, and rd_data is masked while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_console.sv
// -----------------------------------------------------------------------------
// mmio_console
//   Memory-mapped console beside the data memory. 16-byte window at
//   BASE_ADDRESSE; requests outside the window are ignored.
//     +0x0 EXIT     : byte-merged write sets exit_v; read returns exit_code
//     +0x4 TX_DATA  : write with strobe[0] pushes data[7:0]; reads 0
//     +0x8 STATUS   : {count[15:8], overflow[2], full[1], empty[0]}; write clears overflow
//     +0xC CYCLE    : free-running counter; any write zeroes it
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     bus (slave)         : request/response bus, ack one cycle after request
//     tx_data/tx_valid    : head of the TX FIFO, popped when tx_ready is high
//     tx_ready            : sink accepts the head byte
//     exit_v / exit_code  : sticky exit flag and last EXIT value
// -----------------------------------------------------------------------------
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int              xlen          = 32,
    parameter logic [xlen-1:0] BASE_ADDRESSE = 'h100,
    parameter int              FIFO_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    mmio_console_if.slave   bus,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            exit_v,
    output logic [xlen-1:0] exit_code
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------- decode ----------------
    reg_off_e offset;
    logic     sel;
    logic     wr_en;
    logic     rd_en;
    logic     unused_adr_bits;

    assign offset          = reg_off_e'(bus.adr[3:2]);
    assign sel             = (bus.r_v || bus.w_v)
                             && (bus.adr[xlen-1:4] == BASE_ADDRESSE[xlen-1:4]);
    // A simultaneous read and write is a write; its response data is 0.
    assign wr_en           = sel && bus.w_v;
    assign rd_en           = sel && !bus.w_v;
    assign unused_adr_bits = ^bus.adr[1:0];

    // ---------------- TX FIFO ----------------
    logic             tx_push;
    logic             tx_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    assign tx_push  = wr_en && (offset == OFF_TX) && bus.strobe[0];
    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push),
        .wr_data (bus.data[7:0]),
        .pop     (tx_pop),
        .rd_data (tx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Overflow only when the byte is really lost: full with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && (offset == OFF_STATUS)) begin
            overflow <= 1'b0;
        end else if (tx_push && fifo_full && !tx_pop) begin
            overflow <= 1'b1;
        end
    end

    // ---------------- EXIT register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_v    <= 1'b0;
            exit_code <= '0;
        end else if (wr_en && (offset == OFF_EXIT)) begin
            exit_v <= 1'b1;
            for (int i = 0; i < xlen/8; i++) begin
                if (bus.strobe[i]) exit_code[8*i +: 8] <= bus.data[8*i +: 8];
            end
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_q;
    wire  [31:0] cycle_inc = cycle_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (wr_en && (offset == OFF_CYCLE)) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_inc;
        end
    end

    // ---------------- read mux and response ----------------
    logic [xlen-1:0] rd_data;

    // NOTE: every output of a combinational block is given a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        rd_data = '0;
        unique case (offset)
            OFF_EXIT:   rd_data = exit_code;
            OFF_TX:     rd_data = '0;
            OFF_STATUS: rd_data = xlen'(pack_status(fifo_empty, fifo_full, overflow,
                                                    8'(fifo_count)));
            OFF_CYCLE:  rd_data = xlen'(cycle_q);
            default:    rd_data = '0;
        endcase
    end

    // Read data is captured at the request edge, so it reflects the state
    // before any same-edge push, pop or counter increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack  <= 1'b0;
            bus.resp <= '0;
        end else begin
            bus.ack  <= sel;
            bus.resp <= rd_en ? rd_data : '0;
        end
    end

endmodule

// File: doc/mmio_console.md
# mmio_console

Memory-mapped responder on the CPU data-memory request interface (r_v/w_v, address, data, strobe in; resp/ack out), sitting beside the data memory in the simulation top. It gives software an exit/status register, a byte transmit FIFO drained by a ready/valid sink, and a readable free-running cycle counter. Requests outside its 16-byte window are ignored, so it can share the request bus with the data memory.

## Interface
- xlen, 32, data and address width
- BASE_ADDRESSE, 'h100, window base; must be 16-byte aligned
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r_v  in  1  read request, single-cycle pulse
- w_v  in  1  write request, single-cycle pulse
- adr  in  xlen  byte address
- data  in  xlen  write data
- strobe  in  4  byte enables for writes
- resp  out  xlen  read data, valid when ack=1
- ack  out  1  one-cycle response strobe
- tx_data  out  8  head byte of TX FIFO
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts byte
- exit_v  out  1  sticky, program wrote EXIT
- exit_code  out  xlen  last value written to EXIT

## Operation
- Select: sel = (r_v|w_v) and adr[xlen-1:4] == BASE_ADDRESSE[xlen-1:4]; offset = adr[3:2]. adr[1:0] ignored.
- Both r_v and w_v high: treat as write; resp=0.
- Offset 0 EXIT: write merges data into exit_code per strobe byte and sets exit_v; read returns exit_code.
- Offset 1 TX_DATA: write with strobe[0]=1 pushes data[7:0]; write when full drops byte and sets overflow (sticky). strobe[0]=0 is acked, no push. Read returns 0.
- Offset 2 STATUS (read-only): bit0 empty, bit1 full, bit2 overflow, bits[15:8] count; others 0. A write of any value clears overflow.
- Offset 3 CYCLE: 32-bit counter, +1 every cycle, wraps 'hFFFFFFFF -> 0; any write sets it to 0 (counts from 1 the next cycle).
- TX drain: tx_valid = !empty; pop when tx_valid && tx_ready. Push and pop in the same cycle when full: both happen, count unchanged, no overflow. Same cycle when empty: push only, tx_valid rises the following cycle.

## Timing
- Response latency exactly 1: request at edge N -> ack=1 and resp during cycle N+1, ack low afterwards. Back-to-back requests give back-to-back acks.
- Read data sampled at the request edge (CYCLE read returns the value at the request edge; STATUS reflects the state before the same-cycle push/pop).
- Register writes take effect at the request edge.
- Unselected requests: no ack, no state change.
- Reset values: ack=0, resp=0, exit_v=0, exit_code=0, tx_valid=0, tx_data=0, overflow=0, FIFO empty, cycle=0.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending ack is dropped, and FIFO contents are discarded.

## Structure
- Package mmio_console_pkg: offset constants (OFF_EXIT=0, OFF_TX=1, OFF_STATUS=2, OFF_CYCLE=3) and STATUS bit positions.
- Sub-module fifo_sync (WIDTH, DEPTH; push/pop/full/empty/count, pointer wrap with an extra MSB): it is reusable by other blocks.
- Top: decode, register file, response register, cycle counter.

## Test plan
- Reset, then write EXIT 'h2A with strobe 'hF at BASE -> ack next cycle, exit_v=1, exit_code='h2A; read back 'h2A.
- Push 'h48, 'h69 with tx_ready=0 -> STATUS count=2, empty=0; raise tx_ready -> bytes leave in order 'h48, 'h69, then tx_valid=0, empty=1.
- Push 9 bytes into an 8-deep FIFO with tx_ready=0 -> the 9th byte is dropped, STATUS='h0806 (count 8, full, overflow); write STATUS -> overflow clears.
- Full FIFO, push with tx_ready=1 in the same cycle -> count stays 8, overflow stays 0, new byte is at the tail.
- Write CYCLE, then read it 5 cycles later -> resp=5; force the counter to 'hFFFFFFFF and step one cycle -> value 0.
- Read at BASE+'h10 -> no ack; assert rst mid-transaction -> ack=0 and all outputs return to reset values at once.
